// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, processed LSB first, one bit per clock.
// Uses the full-adder cell in its borrow form with a single borrow flip-flop,
// behind a start/done handshake with registered results.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    // One-bit subtractor cell and the shifted result it produces
    logic             bit_d;
    logic             bw_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign bit_d   = sa_q[0] ^ sb_q[0] ^ bw_q;
    assign bw_nxt  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);
    assign res_nxt = {bit_d, res_q[WIDTH-1:1]};

    // Next-state and output logic for the IDLE/SHIFT/DONE sequencer
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d = res_nxt;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                bw_d  = bw_nxt;
                if (cnt_q == LAST_CNT) begin
                    // Last bit: publish the result; the counter is left at
                    // its final value rather than wrapping.
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    diff_d   = res_nxt;
                    borrow_d = bw_nxt;
                    ovf_d    = (amsb_q != bmsb_q) && (res_nxt[WIDTH-1] != amsb_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule
